// File: rtl/arp_eth_tx.sv
// arp_eth_tx: ARP frame transmitter, parallel Ethernet header plus 28-byte big-endian ARP payload on AXI stream
module arp_eth_tx #(
  parameter int DATA_WIDTH = 8,
  parameter bit KEEP_ENABLE = (DATA_WIDTH > 8),
  parameter int KEEP_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s_frame_valid,
  output logic                  s_frame_ready,
  input  logic [47:0]           s_eth_dest_mac,
  input  logic [47:0]           s_eth_src_mac,
  input  logic [15:0]           s_eth_type,
  input  logic [15:0]           s_arp_htype,
  input  logic [15:0]           s_arp_ptype,
  input  logic [15:0]           s_arp_oper,
  input  logic [47:0]           s_arp_sha,
  input  logic [31:0]           s_arp_spa,
  input  logic [47:0]           s_arp_tha,
  input  logic [31:0]           s_arp_tpa,
  output logic                  m_eth_hdr_valid,
  input  logic                  m_eth_hdr_ready,
  output logic [47:0]           m_eth_dest_mac,
  output logic [47:0]           m_eth_src_mac,
  output logic [15:0]           m_eth_type,
  output logic [DATA_WIDTH-1:0] m_eth_payload_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_eth_payload_axis_tkeep,
  output logic                  m_eth_payload_axis_tvalid,
  input  logic                  m_eth_payload_axis_tready,
  output logic                  m_eth_payload_axis_tlast,
  output logic                  m_eth_payload_axis_tuser,
  output logic                  busy
);
  localparam int CYCLE_COUNT = (28 + KEEP_WIDTH - 1) / KEEP_WIDTH;
  localparam int TOT = CYCLE_COUNT * DATA_WIDTH;
  localparam int REM = 28 % KEEP_WIDTH;
  localparam int PW = CYCLE_COUNT > 1 ? $clog2(CYCLE_COUNT) : 1;
  localparam logic [KEEP_WIDTH-1:0] ONES = '1;
  localparam logic [KEEP_WIDTH-1:0] LAST_KEEP = REM == 0 ? ONES : ONES >> (KEEP_WIDTH - REM);
  if (KEEP_WIDTH * 8 != DATA_WIDTH) begin : g_bad_width
    $error("arp_eth_tx: KEEP_WIDTH*8 must equal DATA_WIDTH");
  end
  typedef enum logic {IDLE, SEND_PAYLOAD} state_t;
  state_t state, state_nx;
  logic [PW-1:0] ptr;
  logic [TOT-1:0] sr;
  logic hdr_valid, frame_ready, busy_q, accept, beat, last, hdr_nx;
  assign accept = s_frame_valid && frame_ready;
  assign beat = m_eth_payload_axis_tvalid && m_eth_payload_axis_tready;
  assign last = ptr == PW'(CYCLE_COUNT - 1);
  assign state_nx = accept ? SEND_PAYLOAD : (beat && last) ? IDLE : state;
  assign hdr_nx = accept || (hdr_valid && !m_eth_hdr_ready);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr <= '0;
      hdr_valid <= 1'b0;
      frame_ready <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state <= state_nx;
      hdr_valid <= hdr_nx;
      frame_ready <= state_nx == IDLE && !hdr_nx;
      busy_q <= state_nx == SEND_PAYLOAD || hdr_nx;
      ptr <= (accept || (beat && last)) ? '0 : beat ? ptr + PW'(1) : ptr;
      if (accept) begin
        m_eth_dest_mac <= s_eth_dest_mac;
        m_eth_src_mac <= s_eth_src_mac;
        m_eth_type <= s_eth_type;
        // payload packed first-byte-at-top, zero padded below so the last beat's spare lanes read 0
        sr <= TOT'({s_arp_htype, s_arp_ptype, 8'h06, 8'h04, s_arp_oper,
                    s_arp_sha, s_arp_spa, s_arp_tha, s_arp_tpa}) << (TOT - 224);
      end else if (beat) begin
        sr <= sr << DATA_WIDTH;
      end
    end
  end
  for (genvar i = 0; i < KEEP_WIDTH; i++) begin : g_lane
    assign m_eth_payload_axis_tdata[i*8 +: 8] = sr[TOT-1-8*i -: 8];
  end
  assign m_eth_payload_axis_tkeep = (KEEP_ENABLE && last) ? LAST_KEEP : ONES;
  assign m_eth_payload_axis_tvalid = state == SEND_PAYLOAD;
  assign m_eth_payload_axis_tlast = m_eth_payload_axis_tvalid && last;
  assign m_eth_payload_axis_tuser = 1'b0;
  assign m_eth_hdr_valid = hdr_valid;
  assign s_frame_ready = frame_ready;
  assign busy = busy_q;
endmodule

// File: doc/arp_eth_tx.md
Name: arp_eth_tx

Overview:
- ARP frame transmitter: takes one ARP frame's fields in parallel and emits an Ethernet header in parallel, followed by a 28-byte ARP payload on an AXI stream.
- Sits between the ARP cache/response logic and the Ethernet TX mux. It is the transmit counterpart of the ARP Ethernet receiver.
- Padding to minimum frame length and FCS are handled downstream.

Parameters:
- DATA_WIDTH, 8: payload stream width in bits; legal values 8, 16, 32, 64.
- KEEP_ENABLE, (DATA_WIDTH>8): drive tkeep. If 0, tkeep is tied all-ones.
- KEEP_WIDTH, (DATA_WIDTH/8): bytes per beat. KEEP_WIDTH*8 != DATA_WIDTH is an elaboration error.

Ports:
- clk  in  1  clock; single clock domain.
- rst_n  in  1  synchronous, active-low reset.
- s_frame_valid  in  1  ARP frame request valid.
- s_frame_ready  out  1  request accepted when valid&ready.
- s_eth_dest_mac  in  48  Ethernet destination MAC.
- s_eth_src_mac  in  48  Ethernet source MAC.
- s_eth_type  in  16  ethertype, passed through (normally 0x0806).
- s_arp_htype  in  16  ARP HTYPE.
- s_arp_ptype  in  16  ARP PTYPE.
- s_arp_oper  in  16  ARP OPER.
- s_arp_sha  in  48  sender MAC.
- s_arp_spa  in  32  sender IP.
- s_arp_tha  in  48  target MAC.
- s_arp_tpa  in  32  target IP.
- m_eth_hdr_valid  out  1  Ethernet header valid.
- m_eth_hdr_ready  in  1  header accepted when valid&ready.
- m_eth_dest_mac  out  48  latched destination MAC.
- m_eth_src_mac  out  48  latched source MAC.
- m_eth_type  out  16  latched ethertype.
- m_eth_payload_axis_tdata  out  DATA_WIDTH  payload data.
- m_eth_payload_axis_tkeep  out  KEEP_WIDTH  byte enables.
- m_eth_payload_axis_tvalid  out  1  payload beat valid.
- m_eth_payload_axis_tready  in  1  payload backpressure.
- m_eth_payload_axis_tlast  out  1  last beat of frame.
- m_eth_payload_axis_tuser  out  1  always 0.
- busy  out  1  high while a frame is in flight (header or payload not yet fully accepted).

Behaviour:
- Reset (rst_n=0 at a clk edge): all valids 0, s_frame_ready 0, tlast 0, busy 0, beat pointer 0, state IDLE.
  - Data/MAC output registers are don't-care.
  - s_frame_ready rises on the first clock after rst_n returns high.
- Reset mid-frame: the frame is abandoned immediately, with no tlast and no further beats; the next frame starts clean.
- Payload byte order: big-endian, byte n of the 28-byte payload is transmitted in order:
  - bytes 0-1 HTYPE, 2-3 PTYPE, 4 HLEN, 5 PLEN, 6-7 OPER, 8-13 SHA, 14-17 SPA, 18-23 THA, 24-27 TPA.
  - HLEN is constant 0x06 and PLEN constant 0x04.
  - Byte n goes in beat n/KEEP_WIDTH, lane n%KEEP_WIDTH, i.e. tdata[(n%KEEP_WIDTH)*8 +: 8].
- Beat count: CYCLE_COUNT = ceil(28/KEEP_WIDTH), giving 28/14/7/4 beats for widths 8/16/32/64.
- tkeep: all-ones on every beat except the last. The last beat keeps only the low (28%KEEP_WIDTH) lanes, or all lanes if that remainder is 0. For 64-bit the last tkeep is 0x0F.
- Unused lanes of the last beat drive 0.
- State machine:
  - IDLE: s_frame_ready=1 iff m_eth_hdr_valid=0. On s_frame_valid&s_frame_ready: latch all input fields, set m_eth_hdr_valid=1 and tvalid=1 on the next cycle, pointer=0, go to SEND_PAYLOAD. Request-to-first-beat latency is 1 cycle.
  - SEND_PAYLOAD: s_frame_ready=0. On tvalid&tready, advance the pointer. tlast=1 exactly when pointer==CYCLE_COUNT-1. When the tlast beat is accepted: tvalid drops next cycle, pointer resets to 0, state returns to IDLE.
- Header and payload channels are independent:
  - m_eth_hdr_valid clears on the cycle after m_eth_hdr_ready&valid.
  - The payload may complete before or after the header is taken.
  - The next request is blocked until both channels have completed.
- Output data and tkeep hold stable while tvalid=1 and tready=0. Header outputs hold stable while hdr_valid=1 and hdr_ready=0.
- Back-to-back operation: if the last beat and the header both complete in the same cycle, s_frame_ready=1 the next cycle. The minimum inter-frame gap is 1 idle cycle on the payload stream.
- busy = (state==SEND_PAYLOAD) | m_eth_hdr_valid, registered.
- Inputs are sampled only on the accept cycle; changes afterwards do not affect the frame in flight.

Test Plan:
- DATA_WIDTH=8, one request, sinks always ready:
  - Stimulus: oper=0x0002, sha=02:00:00:00:00:01, spa=192.168.1.128, tha=5A:51:52:53:54:55, tpa=192.168.1.100.
  - Required: hdr_valid and first beat one cycle after accept; 28 beats 00 01 08 00 06 04 00 02 02 00 00 00 00 01 C0 A8 01 80 5A 51 52 53 54 55 C0 A8 01 64; tlast only on beat 28; tuser=0.
- DATA_WIDTH=64, same fields:
  - Required: 4 beats, tkeep FF,FF,FF,0F; beat 0 tdata=0x0200_0406_0008_0100; lanes 4-7 of the last beat are 0.
- Backpressure, DATA_WIDTH=8:
  - Stimulus: tready toggles 1/0 each cycle; hdr_ready held 0 for 40 cycles.
  - Required: data stable during stalls; all 28 bytes delivered; s_frame_ready stays 0 until the header is taken; busy=1 throughout.
- Back-to-back, DATA_WIDTH=32:
  - Stimulus: two requests held valid, oper=1 then oper=2.
  - Required: 7+7 beats, second frame first beat no earlier than 1 cycle after the first frame's tlast, OPER bytes correct per frame.
- Reset mid-frame:
  - Stimulus: assert rst_n=0 at beat 10.
  - Required: tvalid, hdr_valid and busy all 0 the next cycle; s_frame_ready=1 one cycle after release; a fresh frame is then sent complete and correct.
- Input change after accept:
  - Stimulus: alter s_arp_spa on the cycle after accept.
  - Required: the transmitted SPA equals the value latched at accept.
